// File: rtl/roulette_spin.sv
// roulette_spin: spinning-digit core of the roulette game.
// Ports: CLOCK_50 system clock; nrst asynchronous active-low reset;
//        SW[1] run, SW[0] direction (1 = count down), both asynchronous;
//        digit current value 0-9; LEDR one-hot state (IDLE/SPIN/DECEL/HOLD);
//        done high while the result is held.
module roulette_spin #(
    parameter int unsigned STEP_DIV    = 2_500_000,
    parameter int unsigned DECEL_STEPS = 6,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       CLOCK_50,
    input  logic       nrst,
    input  logic [1:0] SW,
    output logic [3:0] digit,
    output logic [3:0] LEDR,
    output logic       done
);
    // One-hot encoding doubles as the LEDR pattern.
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        SPIN  = 4'b0010,
        DECEL = 4'b0100,
        HOLD  = 4'b1000
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  sync1_q, sync2_q;
    logic        run_prev_q;
    logic [15:0] lfsr_q, lfsr_d;
    logic [31:0] cnt_q, cnt_d, period;
    logic [7:0]  k_q, k_d, n_q, n_d;
    logic [3:0]  digit_q, digit_d;
    logic        done_q, done_d;
    logic        run_rise, run_fall, active, tick;

    assign run_rise = sync2_q[1] & ~run_prev_q;
    assign run_fall = ~sync2_q[1] & run_prev_q;
    assign active   = (state_q == SPIN) || (state_q == DECEL);
    // Each deceleration step doubles the step period.
    assign period   = (state_q == DECEL) ? 32'(STEP_DIV) << (k_q + 8'd1) : 32'(STEP_DIV);
    assign tick     = active && (cnt_q == period - 32'd1);
    assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        digit_d = digit_q;
        if (tick)
            digit_d = sync2_q[0] ? ((digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1)
                                 : ((digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1);
        case (state_q)
            IDLE, HOLD: if (run_rise) state_d = SPIN;
            SPIN: if (run_fall) begin
                state_d = DECEL;
                n_d     = 8'(DECEL_STEPS) + {6'd0, lfsr_q[1:0]};
                k_d     = 8'd0;
            end
            DECEL: if (tick) begin
                k_d = k_q + 8'd1;
                if (k_q == n_q - 8'd1) state_d = HOLD;
            end
            default: state_d = IDLE;
        endcase
        // The step timer restarts on every state change, even when a tick coincides.
        cnt_d  = (!active || tick || state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
        done_d = state_d == HOLD;
    end

    always_ff @(posedge CLOCK_50 or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            sync1_q    <= 2'b00;
            sync2_q    <= 2'b00;
            run_prev_q <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            cnt_q      <= 32'd0;
            k_q        <= 8'd0;
            n_q        <= 8'd0;
            digit_q    <= 4'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= SW;
            sync2_q    <= sync1_q;
            run_prev_q <= sync2_q[1];
            lfsr_q     <= lfsr_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            n_q        <= n_d;
            digit_q    <= digit_d;
            done_q     <= done_d;
        end
    end

    assign digit = digit_q;
    assign LEDR  = state_q;
    assign done  = done_q;
endmodule
